// File: rtl/wb_dma_ch_upd.sv
// Channel register-update initiator: turns a finished DMA chunk into adr0/adr1/txsz/csr writes.
// Define WB_DMA_UPD_AM_WRAP_EN to make address increments wrap inside the ch_am0/ch_am1 masks.
module wb_dma_ch_upd #(
  parameter int TXSZ_W = 12,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_req,
  input  logic              upd_err,
  input  logic              ch_dis,
  input  logic [CNT_W-1:0]  xfer_cnt,
  input  logic [31:0]       ch_csr,
  input  logic [31:0]       ch_txsz,
  input  logic [31:0]       ch_adr0,
  input  logic [31:0]       ch_adr1,
  input  logic [31:0]       ch_am0,
  input  logic [31:0]       ch_am1,
  output logic [31:0]       de_adr0,
  output logic [31:0]       de_adr1,
  output logic [TXSZ_W-1:0] de_txsz,
  output logic [31:0]       de_csr,
  output logic              de_adr0_we,
  output logic              de_adr1_we,
  output logic              de_txsz_we,
  output logic              de_csr_we,
  output logic              upd_busy,
  output logic              upd_done
);

  localparam int CSR_EN      = 0;
  localparam int CSR_INC_DST = 3;
  localparam int CSR_INC_SRC = 4;
  localparam int CSR_BUSY    = 10;
  localparam int CSR_DONE    = 11;
  localparam int CSR_ERR     = 12;

  typedef enum logic [2:0] {S_IDLE, S_ADR0, S_ADR1, S_TXSZ, S_CSR} state_t;
  state_t state;

  logic [CNT_W-1:0]  cnt_p0;
  logic [31:0]       csr_p0;
  logic [TXSZ_W-1:0] txsz_p0;
  logic [31:0]       adr1_p0;
  logic [31:0]       wrap0;
  logic [31:0]       wrap1;
  logic [31:0]       adr0_nxt;
  logic [31:0]       adr1_nxt;
  logic [TXSZ_W-1:0] txsz_nxt;
  logic [31:0]       csr_ok;
  logic [31:0]       csr_err;
  logic              unused_ok;

  // Bits set in wrap take the incremented value; the rest keep the old address.
  function automatic logic [31:0] next_adr(input logic [31:0] adr, input logic [31:0] wrap,
                                           input logic [CNT_W-1:0] cnt, input logic inc);
    logic [31:0] sum;
    sum = adr + (32'(cnt) << 2);
    if (inc) return ((adr & ~wrap) | (sum & wrap)) & 32'hFFFF_FFFC;
    return adr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [TXSZ_W-1:0] sat_sub(input logic [TXSZ_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    if (32'(b) >= 32'(a)) return '0;
    return TXSZ_W'(32'(a) - 32'(b));
  endfunction

  function automatic logic [31:0] next_csr(input logic [31:0] csr, input logic err,
                                           input logic fin);
    logic [31:0] c;
    c = csr;
    c[CSR_BUSY] = 1'b0;
    if (err) begin
      c[CSR_ERR] = 1'b1;
      c[CSR_EN]  = 1'b0;
    end else if (fin) begin
      c[CSR_DONE] = 1'b1;
      c[CSR_EN]   = 1'b0;
    end
    return c;
  endfunction

`ifdef WB_DMA_UPD_AM_WRAP_EN
  logic [31:4] am1_p0;
  assign wrap0     = {ch_am0[31:4], 4'b1100};
  assign wrap1     = {am1_p0, 4'b1100};
  assign unused_ok = ^{ch_txsz[31:TXSZ_W], ch_am0[3:0], ch_am1[3:0]};
`else
  assign wrap0     = 32'hFFFF_FFFC;
  assign wrap1     = 32'hFFFF_FFFC;
  assign unused_ok = ^{ch_txsz[31:TXSZ_W], ch_am0, ch_am1};
`endif

  // adr0 and the error CSR are produced on the accept edge, where the live inputs equal the captured copy.
  assign adr0_nxt = next_adr(ch_adr0, wrap0, xfer_cnt, ch_csr[CSR_INC_SRC]);
  assign adr1_nxt = next_adr(adr1_p0, wrap1, cnt_p0, csr_p0[CSR_INC_DST]);
  assign txsz_nxt = sat_sub(txsz_p0, cnt_p0);
  assign csr_ok   = next_csr(csr_p0, 1'b0, txsz_nxt == '0);
  assign csr_err  = next_csr(ch_csr, 1'b1, 1'b0);

  // Stage p0: chunk parameters captured on an accepted request
  always_ff @(posedge clk) begin
    if (state == S_IDLE && upd_req) begin
      cnt_p0  <= xfer_cnt;
      csr_p0  <= ch_csr;
      txsz_p0 <= ch_txsz[TXSZ_W-1:0];
      adr1_p0 <= ch_adr1;
`ifdef WB_DMA_UPD_AM_WRAP_EN
      am1_p0  <= ch_am1[31:4];
`endif
    end
  end

  // Write sequencer: strobes and data registered on entry to each state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      de_adr0    <= '0;
      de_adr1    <= '0;
      de_txsz    <= '0;
      de_csr     <= '0;
      de_adr0_we <= 1'b0;
      de_adr1_we <= 1'b0;
      de_txsz_we <= 1'b0;
      de_csr_we  <= 1'b0;
      upd_busy   <= 1'b0;
      upd_done   <= 1'b0;
    end else begin
      de_adr0_we <= 1'b0;
      de_adr1_we <= 1'b0;
      de_txsz_we <= 1'b0;
      de_csr_we  <= 1'b0;
      upd_done   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (upd_req && !ch_dis) begin
            upd_busy <= 1'b1;
            if (upd_err) begin
              state     <= S_CSR;
              de_csr    <= csr_err;
              de_csr_we <= 1'b1;
              upd_done  <= 1'b1;
            end else begin
              state      <= S_ADR0;
              de_adr0    <= adr0_nxt;
              de_adr0_we <= 1'b1;
            end
          end
        end
        S_ADR0: begin
          if (ch_dis) begin
            state    <= S_IDLE;
            upd_busy <= 1'b0;
          end else begin
            state      <= S_ADR1;
            de_adr1    <= adr1_nxt;
            de_adr1_we <= 1'b1;
          end
        end
        S_ADR1: begin
          if (ch_dis) begin
            state    <= S_IDLE;
            upd_busy <= 1'b0;
          end else begin
            state      <= S_TXSZ;
            de_txsz    <= txsz_nxt;
            de_txsz_we <= 1'b1;
          end
        end
        S_TXSZ: begin
          if (ch_dis) begin
            state    <= S_IDLE;
            upd_busy <= 1'b0;
          end else begin
            state     <= S_CSR;
            de_csr    <= csr_ok;
            de_csr_we <= 1'b1;
            upd_done  <= 1'b1;
          end
        end
        S_CSR: begin
          state    <= S_IDLE;
          upd_busy <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          upd_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dma_ch_upd.sv
// Scoreboard bench for wb_dma_ch_upd: expected register writes are queued by the driver and
// matched by a monitor against every strobe the DUT presents.
module tb_wb_dma_ch_upd;

  localparam int TXSZ_W = 12;
  localparam int CNT_W  = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              upd_req = 1'b0;
  logic              upd_err = 1'b0;
  logic              ch_dis = 1'b0;
  logic [CNT_W-1:0]  xfer_cnt = '0;
  logic [31:0]       ch_csr = '0, ch_txsz = '0, ch_adr0 = '0, ch_adr1 = '0, ch_am0 = '0, ch_am1 = '0;
  logic [31:0]       de_adr0, de_adr1, de_csr;
  logic [TXSZ_W-1:0] de_txsz;
  logic              de_adr0_we, de_adr1_we, de_txsz_we, de_csr_we, upd_busy, upd_done;

  wb_dma_ch_upd #(.TXSZ_W(TXSZ_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .upd_req(upd_req), .upd_err(upd_err), .ch_dis(ch_dis),
    .xfer_cnt(xfer_cnt), .ch_csr(ch_csr), .ch_txsz(ch_txsz), .ch_adr0(ch_adr0),
    .ch_adr1(ch_adr1), .ch_am0(ch_am0), .ch_am1(ch_am1),
    .de_adr0(de_adr0), .de_adr1(de_adr1), .de_txsz(de_txsz), .de_csr(de_csr),
    .de_adr0_we(de_adr0_we), .de_adr1_we(de_adr1_we), .de_txsz_we(de_txsz_we),
    .de_csr_we(de_csr_we), .upd_busy(upd_busy), .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 adr0, 1 adr1, 2 txsz, 3 csr
    logic [31:0] data;
    int          cyc;
  } ev_t;

  typedef struct {
    logic [31:0] csr, txsz, adr0, adr1, am0, am1;
    int          cnt;
    bit          err;
    int          dis_d;  // cycle offset at which ch_dis pulses, 0 = never
    bit          spur;   // extra upd_req while busy
  } req_t;

  ev_t exp_q[$];
  int  nvec = 0;
  int  nerr = 0;
  int  bstart = -10;
  int  bend = -10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word-granular address arithmetic, saturating size, CSR bit rules.
  function automatic logic [31:0] m_adr(input logic [31:0] adr, input logic [31:0] am,
                                        input int cnt, input bit inc);
    logic [31:0] moved;
    if (!inc) return {adr[31:2], 2'b00};
    moved = 32'((adr >> 2) + 32'(cnt)) << 2;
`ifdef WB_DMA_UPD_AM_WRAP_EN
    begin
      logic [31:0] keep;
      keep = {am[31:4], 4'b1100};
      return ((adr & ~keep) | (moved & keep)) & ~32'h3;
    end
`else
    if (am == 32'hDEAD_BEEF) return moved;  // masks carry no meaning without wrap support
    return moved;
`endif
  endfunction

  function automatic int m_txsz(input logic [31:0] txsz, input int cnt);
    int t;
    t = int'(txsz % 32'(1 << TXSZ_W));
    return (t > cnt) ? t - cnt : 0;
  endfunction

  function automatic logic [31:0] m_csr(input logic [31:0] csr, input bit err, input bit fin);
    logic [31:0] c;
    c = csr & ~(32'h1 << 10);
    if (err)      c = (c | (32'h1 << 12)) & ~32'h1;
    else if (fin) c = (c | (32'h1 << 11)) & ~32'h1;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    ch_csr = $urandom; ch_txsz = $urandom; ch_adr0 = $urandom; ch_adr1 = $urandom;
    ch_am0 = $urandom; ch_am1 = $urandom; xfer_cnt = CNT_W'($urandom); upd_err = $urandom_range(0, 1);
  endtask

  task automatic do_req(input req_t r);
    int c, len, t;
    ev_t e;
    c = cyc;
    ch_csr = r.csr; ch_txsz = r.txsz; ch_adr0 = r.adr0; ch_adr1 = r.adr1;
    ch_am0 = r.am0; ch_am1 = r.am1; xfer_cnt = CNT_W'(r.cnt); upd_err = r.err;
    upd_req = 1'b1;
    if (r.err) begin
      e.kind = 3; e.data = m_csr(r.csr, 1'b1, 1'b0); e.cyc = c + 1; exp_q.push_back(e);
      len = 1;
    end else begin
      t = m_txsz(r.txsz, r.cnt);
      len = (r.dis_d != 0 && r.dis_d < 4) ? r.dis_d : 4;
      for (int k = 1; k <= len; k++) begin
        e.kind = k - 1; e.cyc = c + k;
        case (k)
          1: e.data = m_adr(r.adr0, r.am0, r.cnt, r.csr[4]);
          2: e.data = m_adr(r.adr1, r.am1, r.cnt, r.csr[3]);
          3: e.data = 32'(t);
          default: e.data = m_csr(r.csr, 1'b0, t == 0);
        endcase
        exp_q.push_back(e);
      end
    end
    bstart = c;
    bend = c + len;
    tick();
    upd_req = 1'b0;
    scramble();
    for (int k = 1; k <= 6; k++) begin
      ch_dis  = (k == r.dis_d);
      upd_req = (r.spur && k == 2);
      tick();
      scramble();
    end
    ch_dis = 1'b0;
    upd_req = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: one strobe per cycle at most, each matched in order against the scoreboard.
  always @(negedge clk) begin
    int n, kind;
    logic [31:0] act;
    bit exp_done;
    ev_t e;
    if (!rst) begin
      chk("upd_busy", 32'(upd_busy), 32'(cyc > bstart && cyc <= bend));
      n = int'(de_adr0_we) + int'(de_adr1_we) + int'(de_txsz_we) + int'(de_csr_we);
      exp_done = 1'b0;
      if (n > 1) chk("single_strobe", 32'(n), 32'd1);
      if (n == 1) begin
        if (de_adr0_we)      begin kind = 0; act = de_adr0; end
        else if (de_adr1_we) begin kind = 1; act = de_adr1; end
        else if (de_txsz_we) begin kind = 2; act = 32'(de_txsz); end
        else                 begin kind = 3; act = de_csr; end
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'(kind), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", 32'(kind), 32'(e.kind));
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
          chk("strobe_data", act, e.data);
          exp_done = (e.kind == 3);
        end
      end
      chk("upd_done", 32'(upd_done), 32'(exp_done));
    end
  end

  initial begin
    req_t r;
    repeat (3) tick();
    chk("rst_adr0", de_adr0, 32'd0);
    chk("rst_adr1", de_adr1, 32'd0);
    chk("rst_txsz", 32'(de_txsz), 32'd0);
    chk("rst_csr", de_csr, 32'd0);
    chk("rst_flags", {26'd0, de_adr0_we, de_adr1_we, de_txsz_we, de_csr_we, upd_busy, upd_done}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Increment path, saturation, error, abort, back-to-back and mask cases
    r = '{csr: 32'h19, txsz: 32'h40, adr0: 32'h1000, adr1: 32'h2000, am0: 0, am1: 0,
          cnt: 'h10, err: 0, dis_d: 0, spur: 0};
    do_req(r);
    r.txsz = 32'h8;
    do_req(r);
    r.txsz = 32'h40; r.err = 1;
    do_req(r);
    r.err = 0; r.dis_d = 2;
    do_req(r);
    r.dis_d = 0; r.spur = 1;
    do_req(r);
    r = '{csr: 32'h11, txsz: 32'h100, adr0: 32'h1FF0, adr1: 32'h3000, am0: 32'hFF0, am1: 32'h0,
          cnt: 8, err: 0, dis_d: 0, spur: 0};
    do_req(r);
    r.cnt = 0;
    do_req(r);

    // Request together with ch_dis in IDLE is dropped
    ch_csr = 32'h19; xfer_cnt = 9'h4; upd_err = 1'b0; upd_req = 1'b1; ch_dis = 1'b1;
    tick();
    upd_req = 1'b0; ch_dis = 1'b0;
    repeat (5) tick();

    // Asynchronous reset mid-sequence drops the strobes immediately
    r = '{csr: 32'h19, txsz: 32'h40, adr0: 32'h400, adr1: 32'h800, am0: 0, am1: 0,
          cnt: 3, err: 0, dis_d: 0, spur: 0};
    ch_csr = r.csr; ch_txsz = r.txsz; ch_adr0 = r.adr0; ch_adr1 = r.adr1;
    xfer_cnt = CNT_W'(r.cnt); upd_err = 1'b0; upd_req = 1'b1;
    exp_q.push_back('{kind: 0, data: m_adr(r.adr0, 0, r.cnt, 1'b1), cyc: cyc + 1});
    bstart = cyc; bend = cyc + 1;
    tick();
    upd_req = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_strobes", {28'd0, de_adr0_we, de_adr1_we, de_txsz_we, de_csr_we}, 32'd0);
    chk("arst_busy", 32'(upd_busy), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 200; i++) begin
      r.csr   = $urandom;
      r.txsz  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
      r.adr0  = $urandom;
      r.adr1  = $urandom;
      r.am0   = $urandom;
      r.am1   = $urandom;
      r.cnt   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 511));
      r.err   = ($urandom_range(0, 5) == 0);
      r.dis_d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
      r.spur  = !r.err && r.dis_d == 0 && ($urandom_range(0, 2) == 0);
      do_req(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
